ac97_pcm_feeder: RTL
====================

AC97_PCM_FEEDER -- requirements
Module: ac97_pcm_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in stereo sample pairs (power of 2, at least 4).
REQ-002 SHALL have parameter PRIME_LEVEL, default 8, FIFO occupancy required before samples are released (1..DEPTH).
REQ-003 SHALL have port bitclk  input  1  the AC97 bit clock and the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 clears all state.
REQ-005 SHALL have port enable  input  1  1 = feeder active, 0 = idle with FIFO flushed.
REQ-006 SHALL have port mute  input  1  1 = popped samples output as zero.
REQ-007 SHALL have port wr_valid  input  1  upstream offers a sample pair.
REQ-008 SHALL have port wr_ready  output  1  feeder accepts a sample pair this cycle.
REQ-009 SHALL have ports wr_left and wr_right  input  20 each  offered PCM left and right samples.
REQ-010 SHALL have port frame_req  input  1  single-cycle pulse from the frame serializer on its bit-255 frame-load cycle.
REQ-011 SHALL have ports pcm_left and pcm_right  output  20 each  samples for slots 3 and 4.
REQ-012 SHALL have port pcm_valid  output  1  tag valid bit for slots 3 and 4.
REQ-013 SHALL have port fifo_level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port underrun_cnt  output  8  saturating count of underruns.

Function
REQ-015 SHALL store left and right together as one 40-bit FIFO entry; read and write pointers wrap modulo DEPTH.
REQ-016 SHALL drive wr_ready = (state != IDLE) and (registered fifo_level < DEPTH); a write occurs on wr_valid & wr_ready.
REQ-017 SHALL implement states IDLE, PRIME and RUN; reset enters IDLE.
REQ-018 IDLE: SHALL hold the FIFO empty (pointers and level 0), pcm outputs 0, pcm_valid 0, and ignore frame_req.
REQ-019 IDLE SHALL go to PRIME on the cycle after enable=1 is sampled.
REQ-020 In any state, enable=0 sampled SHALL force IDLE on the next edge; the FIFO is flushed and pcm outputs and pcm_valid are zeroed.
REQ-021 PRIME: frame_req SHALL load pcm_left=0, pcm_right=0 and pcm_valid=0 without a pop.
REQ-022 PRIME SHALL go to RUN on the edge after fifo_level >= PRIME_LEVEL is sampled.
REQ-023 RUN with frame_req and fifo_level>0 SHALL pop the head entry and set pcm_valid=1.
REQ-024 In that case pcm_left and pcm_right SHALL be set to the head entry, or to 0 if mute=1.
REQ-025 RUN with frame_req and fifo_level=0 (underrun) SHALL:
- set pcm outputs to 0 and pcm_valid=0;
- increment underrun_cnt, saturating at 255;
- go to PRIME.
REQ-026 pcm outputs and pcm_valid SHALL update exactly 1 bitclk after frame_req is sampled and SHALL remain stable until the next frame_req acts.
REQ-027 A write and a pop in the same cycle SHALL both take effect, leaving fifo_level unchanged.
REQ-028 When full, a same-cycle pop SHALL NOT make wr_ready 1 in that cycle, because wr_ready uses the registered level.
REQ-029 frame_req on consecutive cycles SHALL be treated as independent requests.
REQ-030 underrun_cnt SHALL clear only on reset and SHALL be preserved across IDLE.

Reset
REQ-031 While reset=0, the block SHALL drive:
- wr_ready=0, pcm_left=0, pcm_right=0, pcm_valid=0;
- fifo_level=0, underrun_cnt=0;
- state=IDLE, with pointers cleared.
REQ-032 Assertion of reset SHALL take effect asynchronously; deassertion SHALL be synchronised internally to bitclk, so state leaves IDLE no earlier than the 2nd edge after release.

Verification
REQ-033 The bench SHALL cover reset: reset=0 with wr_valid=1 and frame_req pulsing -> all outputs 0 and no write accepted.
REQ-034 The bench SHALL cover priming:
- stimulus: enable=1; write pairs (L=0x00001..0x00008, R=0xF0001..0xF0008) while pulsing frame_req after the 3rd write;
- response at that frame_req: pcm_valid=0 and outputs 0;
- after the 8th write: state RUN;
- at the next frame_req: pcm_left=0x00001 and pcm_right=0xF0001 one cycle later, pcm_valid=1, fifo_level=7.
REQ-035 The bench SHALL cover full with simultaneous access: fill to 16 -> wr_ready=0 and a held 17th pair is not taken; then frame_req with wr_valid=1 -> pop occurs, fifo_level=15; next cycle wr_ready=1.
REQ-036 The bench SHALL cover underrun: in RUN, drain to 0, then one extra frame_req -> pcm_valid=0, outputs 0, underrun_cnt=1, state PRIME; 256 forced underruns -> underrun_cnt holds at 255.
REQ-037 The bench SHALL cover mute: in RUN with level 5, mute=1 and frame_req -> pcm_left=pcm_right=0, pcm_valid=1, fifo_level=4.
REQ-038 The bench SHALL cover reset mid-stream: in RUN with level 6, reset=0 asserted between edges -> outputs and level 0 immediately; underrun_cnt=0.

Source files
------------

// File: rtl/ac97_pcm_feeder.sv
// AC97 PCM feeder: stereo sample FIFO between an upstream producer and the
// frame serializer. Primes the FIFO before releasing samples, pops one pair
// per frame_req and counts underruns (saturating). Single clock: bitclk.
module ac97_pcm_feeder #(
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                   bitclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   mute,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [19:0]            wr_left,
  input  logic [19:0]            wr_right,
  input  logic                   frame_req,
  output logic [19:0]            pcm_left,
  output logic [19:0]            pcm_right,
  output logic                   pcm_valid,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [19:0]     pl_q, pl_d, pr_q, pr_d;
  logic            pv_q, pv_d;
  logic [7:0]      ucnt_q, ucnt_d;
  logic [39:0]     mem_q [DEPTH];
  logic [39:0]     head;
  logic            push, pop;
  logic [1:0]      rst_sync_q;
  logic            rst_n;

  // Reset asserts immediately, releases two bitclk edges later.
  always_ff @(posedge bitclk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign head         = mem_q[rptr_q];
  assign wr_ready     = (state_q != S_IDLE) && (level_q < FULL_LVL);
  assign push         = wr_valid && wr_ready;
  assign pcm_left     = pl_q;
  assign pcm_right    = pr_q;
  assign pcm_valid    = pv_q;
  assign fifo_level   = level_q;
  assign underrun_cnt = ucnt_q;

  // Sample storage; contents are only observable through the pointers.
  always_ff @(posedge bitclk) begin
    if (push) mem_q[wptr_q] <= {wr_left, wr_right};
  end

  // Next-state: FSM, pop/underrun handling, pointer and level bookkeeping.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    pl_d    = pl_q;
    pr_d    = pr_q;
    pv_d    = pv_q;
    ucnt_d  = ucnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_PRIME;
      end
      S_PRIME: begin
        // Frames still go out while priming, just silent and untagged.
        if (frame_req) begin
          pl_d = '0;
          pr_d = '0;
          pv_d = 1'b0;
        end
        if (level_q >= PRIME_LVL) state_d = S_RUN;
      end
      S_RUN: begin
        if (frame_req) begin
          if (level_q != '0) begin
            pop  = 1'b1;
            pl_d = mute ? 20'd0 : head[39:20];
            pr_d = mute ? 20'd0 : head[19:0];
            pv_d = 1'b1;
          end else begin
            pl_d    = '0;
            pr_d    = '0;
            pv_d    = 1'b0;
            state_d = S_PRIME;
            if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    // Disable wins over everything: flush and silence, keep the counter.
    if (!enable) begin
      state_d = S_IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      pl_d    = '0;
      pr_d    = '0;
      pv_d    = 1'b0;
    end
  end

  // State registers, cleared by the synchronised reset.
  always_ff @(posedge bitclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      pl_q    <= '0;
      pr_q    <= '0;
      pv_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      pv_q    <= pv_d;
      ucnt_q  <= ucnt_d;
    end
  end

endmodule
